// File: rtl/router_input_arbiter.sv
// ---------------------------------------------------------------------------
// router_input_arbiter
//
// Round-robin arbiter that shares the single input port of a Router among
// p_ninputs requesters. The winning requester's message is captured in a
// one-entry output buffer, which drives the Router and drains on ready_in.
// The buffer can drain and refill in the same cycle, so the sustained rate
// is one message per cycle while the Router keeps ready_in high.
//
// Parameters
//   p_nbits      message width, including the destination select MSBs
//   p_ninputs    number of requesters (>= 2)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   valid        per-requester valid
//   ready        per-requester ready, one-hot or zero
//   message_in   requester i message in bits [i*p_nbits +: p_nbits]
//   valid_out    buffer holds a message for the Router
//   ready_in     Router accepts the buffered message this cycle
//   message_out  buffered message
//   grant_id     index of the requester whose message is in the buffer
// ---------------------------------------------------------------------------
module router_input_arbiter #(
    parameter int p_nbits   = 8,
    parameter int p_ninputs = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_ninputs-1:0]           valid,
    output logic [p_ninputs-1:0]           ready,
    input  logic [p_ninputs*p_nbits-1:0]   message_in,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic [p_nbits-1:0]             message_out,
    output logic [$clog2(p_ninputs)-1:0]   grant_id
);

    localparam int IDW = $clog2(p_ninputs);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic [IDW:0]     cand_sum;
    logic             any_valid;
    logic             accept;
    logic             transfer;
    logic [p_nbits-1:0] win_msg;

    // Search valid starting at ptr and wrapping. cand_sum carries one extra
    // bit so the wrap also works when p_ninputs is not a power of two.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < p_ninputs; k++) begin
            cand_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(p_ninputs)) begin
                cand_sum = cand_sum - (IDW+1)'(p_ninputs);
            end
            cand = cand_sum[IDW-1:0];
            if (!any_valid && valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Select the winner's message with a mux so no variable part-select
    // is needed.
    always_comb begin
        win_msg = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            if (winner == IDW'(i)) begin
                win_msg = message_in[i*p_nbits +: p_nbits];
            end
        end
    end

    // The buffer accepts when empty or when it drains this cycle. Reset
    // blocks any handshake so nothing transfers on a reset cycle.
    always_comb begin
        accept   = !reset && ((state == EMPTY) || ready_in);
        transfer = accept && any_valid;
        ready    = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            ready[i] = transfer && (winner == IDW'(i));
        end
        if (winner == IDW'(p_ninputs - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner + 1'b1;
        end
    end

    // Next-state logic for the buffer. A refill wins over a drain, so
    // drain-and-refill in one cycle stays FULL.
    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = FULL;
        end else if ((state == FULL) && ready_in) begin
            state_next = EMPTY;
        end
        valid_out = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Buffer contents and priority pointer change only on a transfer, so
    // idle cycles never rotate priority and a drained buffer keeps its
    // last message and grant_id.
    always_ff @(posedge clk) begin
        if (reset) begin
            message_out <= '0;
            grant_id    <= '0;
            ptr         <= '0;
        end else if (transfer) begin
            message_out <= win_msg;
            grant_id    <= winner;
            ptr         <= ptr_next;
        end
    end

endmodule

// File: tb/tb_router_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_input_arbiter
//
// Directed bench for router_input_arbiter (p_nbits=8, p_ninputs=4).
// Each stimulus cycle carries a hand-computed expected ready vector. When a
// handshake is expected, the matching {grant_id, message} is queued. A
// monitor pops the queue whenever the Router side drains the buffer.
// ---------------------------------------------------------------------------
module tb_router_input_arbiter;

    localparam int NB = 8;
    localparam int NI = 4;

    logic            clk;
    logic            reset;
    logic [NI-1:0]   valid;
    logic [NI-1:0]   ready;
    logic [NI*NB-1:0] message_in;
    logic            valid_out;
    logic            ready_in;
    logic [NB-1:0]   message_out;
    logic [1:0]      grant_id;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb[$];

    router_input_arbiter #(
        .p_nbits   (NB),
        .p_ninputs (NI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .ready       (ready),
        .message_in  (message_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .message_out (message_out),
        .grant_id    (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endfunction

    // Drive one cycle. The caller is at posedge+1. Ready is checked at the
    // negedge against the hand-computed vector, and the expected buffer
    // contents are queued if a handshake is expected.
    task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic rin,
                                 input logic [3:0] exp_rdy, input string name);
        logic [1:0] gid;
        reset    = rst;
        valid    = v;
        ready_in = rin;
        @(negedge clk);
        checkOutput({name, " ready"}, 32'(ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            gid = 2'd0;
            for (int i = 0; i < NI; i++) begin
                if (exp_rdy[i]) gid = 2'(i);
            end
            sb.push_back({gid, message_in[gid*NB +: NB]});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every drain to the Router must match the oldest queued grant.
    always @(negedge clk) begin
        logic [9:0] exp_item;
        if (!reset && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL drain_unexpected: got grant_id=%0d message=0x%0h, expected no drain",
                         grant_id, message_out);
            end else begin
                exp_item = sb.pop_front();
                checkOutput("drain grant_id", 32'(grant_id), 32'(exp_item[9:8]));
                checkOutput("drain message_out", 32'(message_out), 32'(exp_item[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        valid      = '0;
        ready_in   = 1'b0;
        message_in = 32'h44332211;
        @(posedge clk);
        #1;

        // Reset with every requester asserting: no handshake, buffer empty.
        $display("[TB] reset");
        applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000, "reset_c0");
        checkOutput("reset valid_out", 32'(valid_out), 32'd0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000, "reset_c1");
        checkOutput("reset valid_out", 32'(valid_out), 32'd0);
        checkOutput("reset message_out", 32'(message_out), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);

        // Round robin: all requesting, grants rotate 0,1,2,3,0,1,2,3.
        $display("[TB] round robin");
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1, 4'(1 << (c % 4)), "rr");
            checkOutput("rr valid_out", 32'(valid_out), 32'd1);
        end

        // Backpressure: load 8'hA5 from requester 2, then stall for 5 cycles.
        $display("[TB] backpressure");
        message_in = 32'h44A52211;
        applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0100, "bp_load");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0000, "bp_hold");
            checkOutput("bp valid_out", 32'(valid_out), 32'd1);
            checkOutput("bp message_out", 32'(message_out), 32'hA5);
            checkOutput("bp grant_id", 32'(grant_id), 32'd2);
        end
        applyStimulus(1'b0, 4'b1111, 1'b1, 4'b1000, "bp_release");
        checkOutput("bp refill grant_id", 32'(grant_id), 32'd3);

        // Skip idle: ptr=1 with requesters 0 and 3 requesting, so 3 wins, then 0.
        $display("[TB] skip idle");
        applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0001, "skip_setptr");
        applyStimulus(1'b0, 4'b1001, 1'b1, 4'b1000, "skip_first");
        applyStimulus(1'b0, 4'b1001, 1'b1, 4'b0001, "skip_second");

        // Drain to empty: one transfer on requester 1, then nothing requests.
        $display("[TB] drain to empty");
        message_in = 32'h44A53C11;
        applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0010, "drain_load");
        checkOutput("drain valid_out high", 32'(valid_out), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, "drain_idle0");
        checkOutput("drain valid_out low", 32'(valid_out), 32'd0);
        checkOutput("drain held message_out", 32'(message_out), 32'h3C);
        checkOutput("drain held grant_id", 32'(grant_id), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, "drain_idle1");
        checkOutput("drain stays empty", 32'(valid_out), 32'd0);

        // Mid-operation reset: buffer full and stalled, reset discards it.
        $display("[TB] mid-op reset");
        applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0100, "mid_load");
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, "mid_hold");
        checkOutput("mid held valid_out", 32'(valid_out), 32'd1);
        sb.delete();
        applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, "mid_reset");
        checkOutput("mid reset valid_out", 32'(valid_out), 32'd0);
        checkOutput("mid reset message_out", 32'(message_out), 32'd0);
        checkOutput("mid reset grant_id", 32'(grant_id), 32'd0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0001, "mid_post_grant");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, "mid_post_drain");
        checkOutput("mid final valid_out", 32'(valid_out), 32'd0);
        checkOutput("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
